// File: rtl/psum_glb_bank.sv
// GLB-side end of one psum column: streams stored psums to the router and writes the
// accumulated psums it returns back into the same entries.
module psum_glb_bank #(
    parameter int unsigned DATA_W = 21,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic              cfg_first_pass,
    output logic              busy,
    output logic              done,
    output logic              psum_out_valid,
    input  logic              psum_out_ready,
    output logic [DATA_W-1:0] psum_out,
    input  logic              psum_in_valid,
    output logic              psum_in_ready,
    input  logic [DATA_W-1:0] psum_in
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              first_q, first_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              load;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    // Writes trail reads, so an entry is only overwritten after it has been read out.
    assign psum_in_ready  = (state_q == StRun) && (wr_cnt_q < rd_cnt_q);
    assign wr_en          = psum_in_valid && psum_in_ready;
    assign load           = (state_q == StRun) && (!out_valid_q || psum_out_ready)
                            && (rd_cnt_q < num_q);

    assign busy           = (state_q == StRun);
    assign done           = (state_q == StDone);
    assign psum_out_valid = out_valid_q;
    assign psum_out       = out_data_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        first_d     = first_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (load) begin
            out_data_d  = first_q ? '0 : mem[rd_cnt_q[AW-1:0]];
            out_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 1'b1;
        end else if (out_valid_q && psum_out_ready) begin
            out_valid_d = 1'b0;
        end

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    num_d    = cfg_num;
                    first_d  = cfg_first_pass;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            StRun: begin
                if (wr_cnt_q == num_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            num_q       <= '0;
            first_q     <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            first_q     <= first_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[AW-1:0]] <= psum_in;
        end
    end

endmodule

// File: tb/tb_psum_glb_bank.sv
// Directed bench for psum_glb_bank: the bench plays the psum router, echoing a known
// value sequence back for every beat it receives.
module tb_psum_glb_bank;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  cfg_num;
    logic        cfg_first_pass;
    logic        busy;
    logic        done;
    logic        psum_out_valid;
    logic        psum_out_ready;
    logic [20:0] psum_out;
    logic        psum_in_valid;
    logic        psum_in_ready;
    logic [20:0] psum_in;

    int errors = 0;
    int checks = 0;
    int got[$];
    int ret_q[$];

    psum_glb_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_num       (cfg_num),
        .cfg_first_pass(cfg_first_pass),
        .busy          (busy),
        .done          (done),
        .psum_out_valid(psum_out_valid),
        .psum_out_ready(psum_out_ready),
        .psum_out      (psum_out),
        .psum_in_valid (psum_in_valid),
        .psum_in_ready (psum_in_ready),
        .psum_in       (psum_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Router model: collects beats, returns base+index for each, never checks anything.
    task automatic run_pass(input int num, input bit first, input int base, input bit bp,
                            input bit poke, output int n_in, output int stall_err,
                            output int done_cyc, output int done_cnt, output int first_vcyc,
                            output bit timeout);
        int cyc;
        bit pv_stall;
        logic [20:0] pv_data;
        got.delete();
        ret_q.delete();
        n_in = 0; stall_err = 0; done_cyc = -1; done_cnt = 0; first_vcyc = -1;
        timeout = 1'b0; pv_stall = 1'b0; pv_data = '0; cyc = 0;
        start = 1'b1; cfg_num = 7'(num); cfg_first_pass = first;
        psum_out_ready = 1'b1; psum_in_valid = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (poke && cyc == 3) begin
                start = 1'b1; cfg_num = 7'd1; cfg_first_pass = ~first;
            end
            psum_out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            psum_in_valid  = (ret_q.size() > 0);
            psum_in        = (ret_q.size() > 0) ? 21'(ret_q[0]) : '0;
            if (pv_stall && (psum_out_valid !== 1'b1 || psum_out !== pv_data)) stall_err++;
            if (psum_out_valid === 1'b1 && first_vcyc < 0) first_vcyc = cyc;
            pv_stall = psum_out_valid && !psum_out_ready;
            pv_data  = psum_out;
            if (psum_out_valid && psum_out_ready) begin
                got.push_back(int'(psum_out));
                ret_q.push_back(base + got.size() - 1);
            end
            if (psum_in_valid && psum_in_ready) begin
                void'(ret_q.pop_front());
                n_in++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc >= 200) begin timeout = 1'b1; break; end
        end
        psum_out_ready = 1'b0; psum_in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, psum_out_valid, psum_in_ready} !== 4'b0 || psum_out !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b out=%0d required flags=0000 out=0",
                     {busy, done, psum_out_valid, psum_in_ready}, psum_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_first_pass();
        int n_in, st, dc, dn, fv, exp_v[4];
        bit to;
        exp_v = '{0, 0, 0, 0};
        run_pass(4, 1'b1, 5, 1'b0, 1'b0, n_in, st, dc, dn, fv, to);
        checks++;
        if (to || dn !== 1 || dc !== 8 || fv !== 2 || n_in !== 4 || got.size() !== 4) begin
            errors++;
            $display("FAIL first_pass_timing: to=%0d done_cnt=%0d done_cyc=%0d vcyc=%0d in=%0d out=%0d required 0 1 8 2 4 4",
                     to, dn, dc, fv, n_in, got.size());
        end
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i < got.size()) ? got[i] : -1;
            checks++;
            if (g !== exp_v[i]) begin
                errors++;
                $display("FAIL first_pass_beat%0d: got %0d required %0d", i, g, exp_v[i]);
            end
        end
    endtask

    task automatic test_accumulate();
        int n_in, st, dc, dn, fv, exp_v[4];
        bit to;
        exp_v = '{5, 6, 7, 8};
        run_pass(4, 1'b0, 15, 1'b0, 1'b0, n_in, st, dc, dn, fv, to);
        checks++;
        if (to || dn !== 1 || dc !== 8 || n_in !== 4) begin
            errors++;
            $display("FAIL accumulate_timing: to=%0d done_cnt=%0d done_cyc=%0d in=%0d required 0 1 8 4",
                     to, dn, dc, n_in);
        end
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i < got.size()) ? got[i] : -1;
            checks++;
            if (g !== exp_v[i]) begin
                errors++;
                $display("FAIL accumulate_beat%0d: got %0d required %0d", i, g, exp_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_in, st, dc, dn, fv, exp_v[4];
        bit to;
        exp_v = '{15, 16, 17, 18};
        run_pass(4, 1'b0, 25, 1'b1, 1'b0, n_in, st, dc, dn, fv, to);
        checks++;
        if (to || dn !== 1 || st !== 0 || got.size() !== 4 || n_in !== 4) begin
            errors++;
            $display("FAIL backpressure_flow: to=%0d done_cnt=%0d stall_err=%0d out=%0d in=%0d required 0 1 0 4 4",
                     to, dn, st, got.size(), n_in);
        end
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i < got.size()) ? got[i] : -1;
            checks++;
            if (g !== exp_v[i]) begin
                errors++;
                $display("FAIL backpressure_beat%0d: got %0d required %0d", i, g, exp_v[i]);
            end
        end
    endtask

    task automatic test_early_return();
        int n;
        psum_in_valid = 1'b1; psum_in = 21'd99; psum_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (psum_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL early_idle_ready: got %b required 0", psum_in_ready);
        end
        start = 1'b1; cfg_num = 7'd2; cfg_first_pass = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || psum_in_ready !== 1'b0 || psum_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_run_ready: busy=%b in_ready=%b valid=%b required 1 0 0",
                     busy, psum_in_ready, psum_out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (psum_in_ready !== 1'b1 || psum_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_after_read: in_ready=%b valid=%b required 1 1",
                     psum_in_ready, psum_out_valid);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1 || n !== 3) begin
            errors++;
            $display("FAIL early_done: done=%b after %0d cycles required 1 after 3", done, n);
        end
        psum_in_valid = 1'b0; psum_out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_num();
        psum_in_valid = 1'b1; psum_in = 21'd7; psum_out_ready = 1'b1;
        start = 1'b1; cfg_num = 7'd0; cfg_first_pass = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            logic [3:0] exp_f;
            @(posedge clk); #1;
            start = 1'b0;
            exp_f = {(c == 1), (c == 2), 1'b0, 1'b0};
            checks++;
            if ({busy, done, psum_out_valid, psum_in_ready} !== exp_f) begin
                errors++;
                $display("FAIL zero_num_c%0d: flags=%b required %b", c,
                         {busy, done, psum_out_valid, psum_in_ready}, exp_f);
            end
        end
        psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_pass();
        int n_in, st, dc, dn, fv, exp_v[4], done_seen;
        bit to;
        start = 1'b1; cfg_num = 7'd4; cfg_first_pass = 1'b0; psum_out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, psum_out_valid, psum_in_ready} !== 4'b0 || psum_out !== 21'd0) begin
            errors++;
            $display("FAIL midpass_reset: flags=%b out=%0d required 0000 0",
                     {busy, done, psum_out_valid, psum_in_ready}, psum_out);
        end
        psum_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL midpass_no_done: busy/done seen %0d cycles required 0", done_seen);
        end
        exp_v = '{99, 99, 17, 18};
        run_pass(4, 1'b0, 40, 1'b0, 1'b0, n_in, st, dc, dn, fv, to);
        checks++;
        if (to || dn !== 1 || dc !== 8 || n_in !== 4) begin
            errors++;
            $display("FAIL restart_timing: to=%0d done_cnt=%0d done_cyc=%0d in=%0d required 0 1 8 4",
                     to, dn, dc, n_in);
        end
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i < got.size()) ? got[i] : -1;
            checks++;
            if (g !== exp_v[i] + ((i >= 2) ? 10 : 0)) begin
                errors++;
                $display("FAIL restart_beat%0d: got %0d required %0d", i, g,
                         exp_v[i] + ((i >= 2) ? 10 : 0));
            end
        end
    endtask

    task automatic test_start_ignored();
        int n_in, st, dc, dn, fv, exp_v[4];
        bit to;
        exp_v = '{40, 41, 42, 43};
        run_pass(4, 1'b0, 50, 1'b0, 1'b1, n_in, st, dc, dn, fv, to);
        checks++;
        if (to || dn !== 1 || dc !== 8 || got.size() !== 4 || n_in !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_flow: to=%0d done_cnt=%0d done_cyc=%0d out=%0d in=%0d busy=%b required 0 1 8 4 4 0",
                     to, dn, dc, got.size(), n_in, busy);
        end
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i < got.size()) ? got[i] : -1;
            checks++;
            if (g !== exp_v[i]) begin
                errors++;
                $display("FAIL start_ignored_beat%0d: got %0d required %0d", i, g, exp_v[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_num = '0; cfg_first_pass = 1'b0;
        psum_out_ready = 1'b0; psum_in_valid = 1'b0; psum_in = '0;
        test_reset();
        test_first_pass();
        test_accumulate();
        test_backpressure();
        test_early_return();
        test_zero_num();
        test_reset_mid_pass();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
